demux4_stream: RTL and testbench

//  1-to-4 stream demultiplexer with valid/ready handshake; routes each input word to one of

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_slot.sv | 39 +++
 rtl/demux4_stream.sv | 76 +++++++
 tb/tb_demux4_stream.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the demux4_stream block.
//   CH_NUM       number of output channels
//   ch_sel_t     channel select encoding
//   CH_A..CH_D   select codes for the four channels (index = channel)
package demux_pkg;

  localparam int CH_NUM = 4;

  typedef logic [1:0] ch_sel_t;

  localparam ch_sel_t CH_A = 2'b00;
  localparam ch_sel_t CH_B = 2'b01;
  localparam ch_sel_t CH_C = 2'b10;
  localparam ch_sel_t CH_D = 2'b11;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register slice for a single demux channel.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset (slot empty, data zero)
//   ld         load in_data this cycle (caller guarantees ld implies ld_ok)
//   in_data    word to load
//   out_ready  consumer ready
//   out_data   registered data
//   out_valid  registered data valid
//   ld_ok      slot can accept a word this cycle (empty or draining)
module demux_slot #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [N-1:0] in_data,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         ld_ok
);

  assign ld_ok = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ld) begin
      // A load during a drain replaces the word, so valid stays high.
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 valid/ready stream demultiplexer with broadcast.
// Each channel has a one-entry registered output slot (1-cycle latency,
// full throughput). Broadcast loads all four slots or none.
// Optional feature: define DEMUX_STATS_EN to enable saturating per-channel
// accepted-word counters on out_cnt; otherwise out_cnt is tied to zero.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   in_data     input word
//   in_sel      destination channel (00=A, 01=B, 10=C, 11=D)
//   in_bcast    copy word to all channels, in_sel ignored
//   in_valid    input word present
//   in_ready    block accepts word this cycle (independent of in_valid)
//   out_data    per-channel registered data, index = channel
//   out_valid   per-channel data valid
//   out_ready   per-channel consumer ready
//   out_cnt     per-channel accepted-word counters
module demux4_stream
  import demux_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N-1:0]                  in_data,
  input  ch_sel_t                       in_sel,
  input  logic                          in_bcast,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CH_NUM-1:0][N-1:0]      out_data,
  output logic [CH_NUM-1:0]             out_valid,
  input  logic [CH_NUM-1:0]             out_ready,
  output logic [CH_NUM-1:0][CNT_W-1:0]  out_cnt
);

  logic [CH_NUM-1:0] ld_ok;
  logic [CH_NUM-1:0] load;
  logic              xfer;

  // Unicast only looks at the target slot so a stalled channel never
  // blocks traffic to the others.
  assign in_ready = in_bcast ? (&ld_ok) : ld_ok[in_sel];
  assign xfer     = in_valid & in_ready;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_slot
    assign load[k] = xfer & (in_bcast | (in_sel == ch_sel_t'(k)));

    demux_slot #(.N(N)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .ld        (load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k]),
      .out_valid (out_valid[k]),
      .ld_ok     (ld_ok[k])
    );
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        // Saturate at all-ones rather than wrap.
        if (load[k] && (out_cnt[k] != {CNT_W{1'b1}}))
          out_cnt[k] <= out_cnt[k] + 1'b1;
      end
    end
  end
`else
  assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
module tb_demux4_stream;
  import demux_pkg::*;

`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          in_data;
  ch_sel_t             in_sel;
  logic                in_bcast;
  logic                in_valid;
  logic                in_ready;
  logic [3:0][3:0]     out_data;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [3:0][CW-1:0]  out_cnt;

  int errors = 0;
  int checks = 0;

  // reference model: per-channel expected-word queues plus occupancy and counters
  logic [3:0] q[4][$];
  logic [3:0] m_valid;
  int         m_cnt[4];

  demux4_stream #(.N(4), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = '0;
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      m_cnt[k] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    for (int k = 0; k < 4; k++) begin
      if (m_valid[k]) check($sformatf("%s_data%0d", tag, k), 32'(out_data[k]), 32'(q[k][0]));
      check($sformatf("%s_cnt%0d", tag, k), 32'(out_cnt[k]), 32'(m_cnt[k]));
    end
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cycle(input logic [3:0] d, input ch_sel_t s, input logic b,
                       input logic v, input logic [3:0] ordy, input string tag);
    logic [3:0] ldok;
    logic       rdy;
    in_data = d; in_sel = s; in_bcast = b; in_valid = v; out_ready = ordy;
    #1;
    ldok = ~m_valid | ordy;
    rdy  = b ? (&ldok) : ldok[s];
    check({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    for (int k = 0; k < 4; k++) begin
      if (m_valid[k] && ordy[k]) begin
        check($sformatf("%s_pop%0d", tag, k), 32'(out_data[k]), 32'(q[k][0]));
        void'(q[k].pop_front());
        m_valid[k] = 1'b0;
      end
    end
    if (v && rdy) begin
      for (int k = 0; k < 4; k++) begin
        if (b || (s == ch_sel_t'(k))) begin
          q[k].push_back(d);
          m_valid[k] = 1'b1;
          if (STATS && m_cnt[k] < SAT) m_cnt[k]++;
        end
      end
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_valid_async"}, 32'(out_valid), 32'h0);
    check({tag, "_data_async"},  32'(out_data), 32'h0);
    check({tag, "_cnt_async"},   32'(out_cnt), 32'h0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_sel = CH_A; in_bcast = 1'b0; in_valid = 1'b0;
    out_ready = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data), 32'h0);
    check("rst_cnt",   32'(out_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    reset = 1'b0;

    // reset mid-stream with B holding 5
    cycle(4'h5, CH_B, 1'b0, 1'b1, 4'b0000, "t1_load");
    cycle(4'h0, CH_A, 1'b0, 1'b0, 4'b0000, "t1_hold");
    check("t1_b_holds", 32'(out_data[1]), 32'h5);
    reset_pulse("t1_rst");
    cycle(4'h0, CH_A, 1'b0, 1'b0, 4'b0000, "t1_post");

    // unicast to C
    cycle(4'hA, CH_C, 1'b0, 1'b1, 4'b1111, "t2_send");
    check("t2_valid", 32'(out_valid), 32'b0100);
    check("t2_data2", 32'(out_data[2]), 32'hA);
    cycle(4'h0, CH_A, 1'b0, 1'b0, 4'b1111, "t2_drain");

    // backpressure on B
    cycle(4'h3, CH_B, 1'b0, 1'b1, 4'b1101, "t3_first");
    cycle(4'h7, CH_B, 1'b0, 1'b1, 4'b1101, "t3_stall");
    check("t3_stall_data1", 32'(out_data[1]), 32'h3);
    cycle(4'h7, CH_B, 1'b0, 1'b1, 4'b1111, "t3_release");
    check("t3_rel_valid1", 32'(out_valid[1]), 32'h1);
    check("t3_rel_data1",  32'(out_data[1]), 32'h7);

    // D proceeds while B is full and stalled
    cycle(4'h0, CH_A, 1'b0, 1'b0, 4'b1101, "t4_idle");
    cycle(4'h9, CH_D, 1'b0, 1'b1, 4'b1101, "t4_send");
    check("t4_data3", 32'(out_data[3]), 32'h9);
    check("t4_b_kept", 32'(out_data[1]), 32'h7);
    cycle(4'h0, CH_A, 1'b0, 1'b0, 4'b1111, "t4_drain");

    // broadcast, all-or-nothing
    cycle(4'h1, CH_C, 1'b0, 1'b1, 4'b1011, "t5_fillc");
    cycle(4'hC, CH_A, 1'b1, 1'b1, 4'b1011, "t5_blocked");
    check("t5_blk_valid", 32'(out_valid), 32'b0100);
    check("t5_blk_data2", 32'(out_data[2]), 32'h1);
    cycle(4'hC, CH_A, 1'b1, 1'b1, 4'b1111, "t5_go");
    check("t5_valid", 32'(out_valid), 32'b1111);
    check("t5_data",  32'(out_data), 32'hCCCC);
    cycle(4'h0, CH_A, 1'b0, 1'b0, 4'b1111, "t5_drain");

    // counter saturation on A
    reset_pulse("t6_rst");
    for (int i = 0; i < 20; i++)
      cycle(4'(i), CH_A, 1'b0, 1'b1, 4'b1111, "t6_burst");
    cycle(4'h0, CH_A, 1'b0, 1'b0, 4'b1111, "t6_drain");
    check("t6_cnt0", 32'(out_cnt[0]), STATS ? 32'd15 : 32'd0);
    check("t6_cnt_others", 32'({out_cnt[3], out_cnt[2], out_cnt[1]}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
